// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its demand/lamp-decode neighbours.
// The master side drives demand and preemption; the slave side (the scheduler) drives lamp state.
interface intersection_phase_scheduler_if #(
    parameter int CNT_W = 5
);
    logic [3:0]       req;
    logic             extend;
    logic             preempt;
    logic [1:0]       preempt_phase;
    logic [3:0]       grant;
    logic [3:0]       yellow;
    logic [3:0]       pending;
    logic [1:0]       cur_phase;
    logic [CNT_W-1:0] phase_timer;
    logic             busy;

    modport master (
        output req, extend, preempt, preempt_phase,
        input  grant, yellow, pending, cur_phase, phase_timer, busy
    );

    modport slave (
        input  req, extend, preempt, preempt_phase,
        output grant, yellow, pending, cur_phase, phase_timer, busy
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a four-phase intersection
// (NS, EW, ped-NS, ped-EW) with yellow/all-red clearance, min/max green and preemption.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no phase active, all lamps dark, waiting for demand/preempt
// ST_GREEN  | grant[cur_phase] lit, min/max/extend/preempt rules decide exit
// ST_YELLOW | yellow[cur_phase] lit for YELLOW_T cycles
// ST_ALLRED | all lamps dark for ALLRED_T cycles, then next green or idle
module intersection_phase_scheduler #(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 5
) (
    input logic                          clk,
    input logic                          rst,
    intersection_phase_scheduler_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;
    localparam logic [1:0] ST_ALLRED = 2'd3;

    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] phase_timer;
    logic [CNT_W-1:0] timer_nxt;
    logic [1:0]       cur_phase;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;
    logic [3:0]       pending;
    logic [3:0]       pending_nxt;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       prev;
    logic [3:0]       pulse;
    logic [3:0]       phase_mask;
    logic [3:0]       capture_mask;
    logic [3:0]       clear_mask;
    logic             enter_green;
    logic             any_demand;
    logic             other_demand;
    logic             is_ped;
    logic             preempt_away;
    logic             extend_hold;
    logic             green_done;

    // Requests arrive asynchronously; only the synchronised rising edge registers demand.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
            prev  <= 4'b0000;
        end else begin
            sync1 <= bus.req;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse        = sync2 & ~prev;
    assign phase_mask   = 4'b0001 << cur_phase;
    assign capture_mask = (state == ST_GREEN) ? phase_mask : 4'b0000;
    assign any_demand   = (|pending) | bus.preempt;
    assign other_demand = |(pending & ~phase_mask);
    assign is_ped       = cur_phase[1];

    always_comb begin
        winner = cur_phase + 2'd1;
        found  = 1'b0;
        cand   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = cur_phase + 2'(k);
            if (!found && pending[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        if (bus.preempt) begin
            winner = bus.preempt_phase;
        end
    end

    assign preempt_away = bus.preempt && (bus.preempt_phase != cur_phase);
    assign extend_hold  = bus.extend && !is_ped && (phase_timer < MAX_LAST);
    assign green_done   = !bus.preempt && (phase_timer >= MIN_LAST) &&
                          (is_ped || other_demand) && !extend_hold;

    always_comb begin
        state_nxt   = state;
        enter_green = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_demand) begin
                    state_nxt   = ST_GREEN;
                    enter_green = 1'b1;
                end
            end
            ST_GREEN: begin
                if (preempt_away || green_done) begin
                    state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (phase_timer >= YELLOW_LAST) begin
                    state_nxt = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (phase_timer >= ALLRED_LAST) begin
                    if (any_demand) begin
                        state_nxt   = ST_GREEN;
                        enter_green = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A resting vehicle green holds its timer at the cap so it never wraps.
    always_comb begin
        if ((state_nxt != state) || (state == ST_IDLE)) begin
            timer_nxt = '0;
        end else if ((state == ST_GREEN) && (phase_timer >= MAX_LAST)) begin
            timer_nxt = MAX_LAST;
        end else begin
            timer_nxt = phase_timer + CNT_W'(1);
        end
    end

    assign clear_mask  = enter_green ? (4'b0001 << winner) : 4'b0000;
    assign pending_nxt = (pending | (pulse & ~capture_mask)) & ~clear_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase_timer <= '0;
            cur_phase   <= 2'd3;
            pending     <= 4'b0000;
        end else begin
            state       <= state_nxt;
            phase_timer <= timer_nxt;
            pending     <= pending_nxt;
            if (enter_green) begin
                cur_phase <= winner;
            end
        end
    end

    assign bus.grant       = (state == ST_GREEN)  ? phase_mask : 4'b0000;
    assign bus.yellow      = (state == ST_YELLOW) ? phase_mask : 4'b0000;
    assign bus.pending     = pending;
    assign bus.cur_phase   = cur_phase;
    assign bus.phase_timer = phase_timer;
    assign bus.busy        = (state != ST_IDLE);

endmodule
